uart_tx_fifo: RTL and testbench

- 8N1 UART transmitter. It is the transmit-side counterpart of the existing UART receiver and is driven from the same UART config values.
- Bytes come from core logic over a valid/ready handshake into a small FIFO, then are serialized LSB-first on `tx`.
- Frames go out back-to-back with no idle gap while the FIFO is non-empty.

---
 rtl/uart_tx_fifo.sv | 247 ++++++++++++++++++++++++
 tb/tb_uart_tx_fifo.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - UART transmitter (8N1 default) fed from a small byte FIFO
//
// Bytes enter over a data/data_valid/data_ready handshake, are buffered in a
// FIFO_DEPTH-entry FIFO, and are serialized LSB-first on tx with one start bit
// and one stop bit. Frames are sent back-to-back while the FIFO holds data.
//
// Optional feature: define UART_TX_PARITY_EN to insert a parity bit between the
// last data bit and the stop bit (even parity when PARITY_ODD=0, odd when 1).

module uart_tx_fifo #(
    parameter int CLK_FREQ   = 50000000,
    parameter int BAUD_RATE  = 115200,
    parameter int WIDTH      = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int PARITY_ODD = 0
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [WIDTH-1:0]              data,
    input  logic                          data_valid,
    output logic                          data_ready,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int CLOCKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int BW = (CLOCKS_PER_BIT > 2) ? $clog2(CLOCKS_PER_BIT) : 1;
    localparam int NW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    localparam logic [BW-1:0] BAUD_RELOAD = BW'(CLOCKS_PER_BIT - 1);
    localparam logic [NW-1:0] LAST_BIT    = NW'(WIDTH - 1);
    localparam logic [CW-1:0] FULL_COUNT  = CW'(FIFO_DEPTH);

    // Reject configurations the bit timer or the pointer wrap cannot support.
    if (CLOCKS_PER_BIT < 2) begin : g_bad_baud
        $error("uart_tx_fifo: CLK_FREQ/BAUD_RATE must be at least 2");
    end
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("uart_tx_fifo: FIFO_DEPTH must be a power of 2 and at least 2");
    end
    if ((PARITY_ODD != 0) && (PARITY_ODD != 1)) begin : g_bad_parity
        $error("uart_tx_fifo: PARITY_ODD must be 0 or 1");
    end

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_STOP   = 3'd3
`ifdef UART_TX_PARITY_EN
        ,
        S_PARITY = 3'd4
`endif
    } state_t;

    // FIFO storage and bookkeeping
    logic [WIDTH-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [WIDTH-1:0] fifo_head;
    logic             push;
    logic             pop;
    logic             fifo_nonempty;

    // Serializer state
    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] shift_q;
    logic [WIDTH-1:0] shift_d;
    logic [BW-1:0]    baud_q;
    logic [BW-1:0]    baud_d;
    logic [NW-1:0]    bit_q;
    logic [NW-1:0]    bit_d;
    logic             tx_q;
    logic             tx_d;
    logic             bit_done;
`ifdef UART_TX_PARITY_EN
    logic             parity_q;
    logic             parity_d;
`endif

    // Ready depends only on the registered count, so a pop in the same cycle
    // never opens room for a push while the FIFO is full.
    assign data_ready    = (fifo_count != FULL_COUNT);
    assign push          = data_valid & data_ready;
    assign fifo_nonempty = (fifo_count != '0);
    assign fifo_head     = mem[rd_ptr];
    assign bit_done      = (baud_q == '0);

    assign tx   = tx_q;
    assign busy = (state_q != S_IDLE);

    // FIFO storage write; contents need no reset because the pointers do.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= data;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at power-of-2 depth.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Serializer state register; reset drives the line idle immediately.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            shift_q  <= '0;
            baud_q   <= '0;
            bit_q    <= '0;
            tx_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            shift_q  <= shift_d;
            baud_q   <= baud_d;
            bit_q    <= bit_d;
            tx_q     <= tx_d;
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    // Next-state logic: each bit lasts until the down-counter hits zero, and a
    // new byte is popped either from IDLE or straight out of STOP so frames
    // run back-to-back without an idle cycle between them.
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        baud_d   = baud_q;
        bit_d    = bit_q;
        tx_d     = tx_q;
        pop      = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (fifo_nonempty) begin
                    pop      = 1'b1;
                    shift_d  = fifo_head;
                    baud_d   = BAUD_RELOAD;
                    state_d  = S_START;
                    tx_d     = 1'b0;
`ifdef UART_TX_PARITY_EN
                    parity_d = (^fifo_head) ^ (PARITY_ODD != 0);
`endif
                end else begin
                    tx_d = 1'b1;
                end
            end

            S_START: begin
                if (bit_done) begin
                    state_d = S_DATA;
                    tx_d    = shift_q[0];
                    bit_d   = '0;
                    baud_d  = BAUD_RELOAD;
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end

            S_DATA: begin
                if (bit_done) begin
                    baud_d = BAUD_RELOAD;
                    if (bit_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
                        tx_d    = parity_q;
`else
                        state_d = S_STOP;
                        tx_d    = 1'b1;
`endif
                    end else begin
                        shift_d = shift_q >> 1;
                        tx_d    = shift_d[0];
                        bit_d   = bit_q + 1'b1;
                    end
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end

`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (bit_done) begin
                    state_d = S_STOP;
                    tx_d    = 1'b1;
                    baud_d  = BAUD_RELOAD;
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end
`endif

            S_STOP: begin
                if (bit_done) begin
                    if (fifo_nonempty) begin
                        pop      = 1'b1;
                        shift_d  = fifo_head;
                        baud_d   = BAUD_RELOAD;
                        state_d  = S_START;
                        tx_d     = 1'b0;
`ifdef UART_TX_PARITY_EN
                        parity_d = (^fifo_head) ^ (PARITY_ODD != 0);
`endif
                    end else begin
                        state_d = S_IDLE;
                        tx_d    = 1'b1;
                    end
                end else begin
                    baud_d = baud_q - 1'b1;
                end
            end

            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - self-checking bench for uart_tx_fifo (CPB=16, depth 4)

module tb_uart_tx_fifo;

    localparam int CPB  = 16;
    localparam int PODD = 0;
`ifdef UART_TX_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif
    localparam int FL = NB * CPB;
    localparam int NV = 8;

    logic       clock = 1'b0;
    logic       reset;
    logic [7:0] data;
    logic       data_valid;
    logic       data_ready;
    logic       tx;
    logic       busy;
    logic [2:0] fifo_count;

    uart_tx_fifo #(
        .CLK_FREQ   (16),
        .BAUD_RATE  (1),
        .WIDTH      (8),
        .FIFO_DEPTH (4),
        .PARITY_ODD (PODD)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .data       (data),
        .data_valid (data_valid),
        .data_ready (data_ready),
        .tx         (tx),
        .busy       (busy),
        .fifo_count (fifo_count)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] d;
        logic [9:0] frame;
        logic       par;
    } vec_t;

    vec_t vecs[NV];

    int tests = 0;
    int fails = 0;

    logic [NB-1:0] sb[$];
    logic [7:0]    to_send[$];
    int            acc_cyc[$];

    logic [NB-1:0] cap_bits;
    bit            cap_uniform;
    bit            cap_timeout;
    int            cap_start;
    int            starts[6];
    int            bad;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic logic [NB-1:0] exp_frame(input logic [7:0] d);
`ifdef UART_TX_PARITY_EN
        logic p;
        p = (^d) ^ (PODD != 0);
        return {1'b1, p, d, 1'b0};
`else
        return {1'b1, d, 1'b0};
`endif
    endfunction

    function automatic logic [NB-1:0] vec_frame(input vec_t v);
`ifdef UART_TX_PARITY_EN
        return {v.frame[9], v.par, v.frame[8:0]};
`else
        return v.frame;
`endif
    endfunction

    // Drives bytes from to_send with data_valid held; records accept edges.
    task automatic push_seq();
        int  n = 0;
        logic rdy;
        bit   pushed;
        while (to_send.size() > 0 && n < 4000) begin
            data       = to_send[0];
            data_valid = 1'b1;
            rdy        = data_ready;
            pushed     = 1'b0;
            @(posedge clock);
            if (rdy) begin
                sb.push_back(exp_frame(to_send[0]));
                void'(to_send.pop_front());
                pushed = 1'b1;
            end
            @(negedge clock);
            if (pushed) acc_cyc.push_back(cyc);
            n++;
        end
        data_valid = 1'b0;
        check("push_timeout", to_send.size(), 0);
        to_send.delete();
    endtask

    // Waits for a start bit, then samples every cycle of the frame.
    task automatic capture_frame();
        int n = 0;
        cap_uniform = 1'b1;
        cap_timeout = 1'b0;
        cap_bits    = '0;
        @(negedge clock);
        while (tx !== 1'b0 && n < 3000) begin
            @(negedge clock);
            n++;
        end
        if (tx !== 1'b0) begin
            cap_timeout = 1'b1;
            return;
        end
        cap_start = cyc;
        for (int b = 0; b < NB; b++) begin
            for (int s = 0; s < CPB; s++) begin
                if (b != 0 || s != 0) @(negedge clock);
                if (s == 0) cap_bits[b] = tx;
                else if (tx !== cap_bits[b]) cap_uniform = 1'b0;
                if (busy !== 1'b1) cap_uniform = 1'b0;
            end
        end
    endtask

    task automatic capture_and_score(input string name);
        logic [NB-1:0] e;
        capture_frame();
        check({name, "_timeout"}, cap_timeout, 0);
        check({name, "_uniform"}, cap_uniform, 1);
        if (sb.size() == 0) begin
            check({name, "_sb_empty"}, 1, 0);
        end else begin
            e = sb.pop_front();
            check({name, "_frame"}, cap_bits, e);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{8'hA5, 10'b1_10100101_0, 1'b0};
        vecs[1] = '{8'h00, 10'b1_00000000_0, 1'b0};
        vecs[2] = '{8'hFF, 10'b1_11111111_0, 1'b0};
        vecs[3] = '{8'h55, 10'b1_01010101_0, 1'b0};
        vecs[4] = '{8'h07, 10'b1_00000111_0, 1'b1};
        vecs[5] = '{8'h3C, 10'b1_00111100_0, 1'b0};
        vecs[6] = '{8'h01, 10'b1_00000001_0, 1'b1};
        vecs[7] = '{8'h80, 10'b1_10000000_0, 1'b1};

        reset      = 1'b1;
        data       = 8'h00;
        data_valid = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_tx", tx, 1);
        check("rst_busy", busy, 0);
        check("rst_ready", data_ready, 1);
        check("rst_count", fifo_count, 0);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        // Single-byte frames from the vector table
        for (int i = 0; i < NV; i++) begin
            acc_cyc.delete();
            to_send.push_back(vecs[i].d);
            fork
                push_seq();
                capture_and_score("vec");
            join
            check("vec_table_frame", cap_bits, vec_frame(vecs[i]));
            if (acc_cyc.size() > 0) check("vec_latency", cap_start - acc_cyc[0], 1);
            @(negedge clock);
            check("vec_busy_end", busy, 0);
            check("vec_tx_idle", tx, 1);
            repeat (3) @(negedge clock);
        end

        // Back-to-back frames
        acc_cyc.delete();
        to_send = '{8'h00, 8'hFF, 8'h55};
        fork
            push_seq();
            begin
                for (int k = 0; k < 3; k++) begin
                    capture_and_score("b2b");
                    starts[k] = cap_start;
                end
            end
        join
        if (acc_cyc.size() == 3) check("b2b_accept", acc_cyc[2] - acc_cyc[0], 2);
        else check("b2b_accept_n", acc_cyc.size(), 3);
        check("b2b_gap1", starts[1] - starts[0], FL);
        check("b2b_gap2", starts[2] - starts[1], FL);
        check("b2b_total", starts[2] + FL - starts[0], 3 * FL);
        @(negedge clock);
        check("b2b_busy_end", busy, 0);
        repeat (3) @(negedge clock);

        // Full FIFO with six bytes
        acc_cyc.delete();
        to_send = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h66, 8'h99};
        fork
            push_seq();
            begin
                for (int k = 0; k < 6; k++) capture_and_score("full");
            end
            begin
                int n = 0;
                while (acc_cyc.size() < 5 && n < 100) begin
                    @(negedge clock);
                    n++;
                end
                check("full_five_accepted", acc_cyc.size() >= 5, 1);
                if (acc_cyc.size() >= 5) begin
                    check("full_five_cycles", acc_cyc[4] - acc_cyc[0], 4);
                    while (cyc < acc_cyc[0] + 100) @(negedge clock);
                    check("full_ready_100", data_ready, 0);
                    check("full_count_100", fifo_count, 4);
                    while (cyc < acc_cyc[0] + 150) @(negedge clock);
                    check("full_ready_150", data_ready, 0);
                    check("full_count_150", fifo_count, 4);
                end
            end
        join
        if (acc_cyc.size() == 6) check("full_sixth_late", acc_cyc[5] - acc_cyc[0] >= 160, 1);
        else check("full_accept_n", acc_cyc.size(), 6);
        repeat (3) @(negedge clock);

        // Reset in the middle of a frame with two bytes queued
        acc_cyc.delete();
        to_send = '{8'hA1, 8'hB2, 8'hC3};
        fork
            push_seq();
            begin
                int n = 0;
                @(negedge clock);
                while (tx !== 1'b0 && n < 100) begin
                    @(negedge clock);
                    n++;
                end
                repeat (49) @(negedge clock);
            end
        join
        check("mid_pre_count", fifo_count, 2);
        check("mid_pre_busy", busy, 1);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_tx", tx, 1);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_count", fifo_count, 0);
        check("mid_rst_ready", data_ready, 1);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        sb.delete();
        bad = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clock);
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        check("mid_post_idle", bad, 0);
        check("mid_post_count", fifo_count, 0);

        // Data toggling while data_valid is low must be ignored
        bad = 0;
        data_valid = 1'b0;
        for (int c = 0; c < 100; c++) begin
            data = (c % 2 == 0) ? 8'h5A : 8'hA5;
            @(negedge clock);
            if (fifo_count !== 3'd0 || tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        check("hyg_no_push", bad, 0);
        check("hyg_count", fifo_count, 0);
        check("hyg_sb_empty", sb.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
